// File: rtl/vid_timing_gen.sv
// Raster timing generator for the HDMI transmit path.
// Free-running H/V counters issue pixel read requests toward a frame/line
// buffer. The request-stage flags ride a register delay line matched to the
// buffer read latency, so that Hsync, Vsync, Active_pix, pixel_out and the
// start pulses reach the encoder mutually aligned.
module vid_timing_gen #(
    parameter int H_RES_PIX      = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_RES_PIX      = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int H_SYNC_POL     = 0,
    parameter int V_SYNC_POL     = 0,
    parameter int READ_LATENCY   = 2,
    parameter int BITS_PER_PIXEL = 24,
    localparam int H_TOTAL       = H_RES_PIX + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL       = V_RES_PIX + V_FRONT + V_SYNC + V_BACK,
    // narrowest widths that still hold H_TOTAL-1 / V_TOTAL-1
    localparam int H_CNT_BITS    = $clog2(H_TOTAL),
    localparam int V_CNT_BITS    = $clog2(V_TOTAL)
) (
    input  logic                      vid_clk,
    input  logic                      reset,
    output logic                      pix_req,
    output logic [H_CNT_BITS-1:0]     req_hpos,
    output logic [V_CNT_BITS-1:0]     req_vpos,
    input  logic [BITS_PER_PIXEL-1:0] pixel_in,
    output logic                      Hsync,
    output logic                      Vsync,
    output logic                      Active_pix,
    output logic [BITS_PER_PIXEL-1:0] pixel_out,
    output logic                      line_start,
    output logic                      frame_start
);

    // One extra bit on the compare side so end-of-range constants equal to
    // the total count never wrap when the total is a power of two.
    localparam int HW = H_CNT_BITS + 1;
    localparam int VW = V_CNT_BITS + 1;

    localparam logic [H_CNT_BITS-1:0] H_LAST   = H_CNT_BITS'(H_TOTAL - 1);
    localparam logic [V_CNT_BITS-1:0] V_LAST   = V_CNT_BITS'(V_TOTAL - 1);
    localparam logic [H_CNT_BITS-1:0] H_ZERO   = H_CNT_BITS'(0);
    localparam logic [V_CNT_BITS-1:0] V_ZERO   = V_CNT_BITS'(0);
    localparam logic [H_CNT_BITS-1:0] H_ONE    = H_CNT_BITS'(1);
    localparam logic [V_CNT_BITS-1:0] V_ONE    = V_CNT_BITS'(1);

    localparam logic [HW-1:0] H_ACT_END = HW'(H_RES_PIX);
    localparam logic [HW-1:0] HS_BEG    = HW'(H_RES_PIX + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_RES_PIX + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END = VW'(V_RES_PIX);
    localparam logic [VW-1:0] VS_BEG    = VW'(V_RES_PIX + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_RES_PIX + V_FRONT + V_SYNC);

    localparam logic HS_ON = 1'(H_SYNC_POL);
    localparam logic VS_ON = 1'(V_SYNC_POL);

    // Bit positions inside one delay-line stage
    localparam int P_REQ = 4;
    localparam int P_HS  = 3;
    localparam int P_VS  = 2;
    localparam int P_LS  = 1;
    localparam int P_FS  = 0;

    logic [H_CNT_BITS-1:0] h_nxt_s;
    logic [V_CNT_BITS-1:0] v_nxt_s;
    logic [HW-1:0]         h_ext_s;
    logic [VW-1:0]         v_ext_s;
    logic [4:0]            flags_nxt_s;
    logic [4:0]            tail_s;

    // Stage 0 is the request stage itself; stage READ_LATENCY is the one
    // lined up with pixel_in.
    logic [4:0] stage_r [0:READ_LATENCY];

    // Next raster position: horizontal wrap carries into the line counter
    always_comb begin
        h_nxt_s = req_hpos + H_ONE;
        v_nxt_s = req_vpos;
        if (req_hpos == H_LAST) begin
            h_nxt_s = H_ZERO;
            if (req_vpos == V_LAST) begin
                v_nxt_s = V_ZERO;
            end else begin
                v_nxt_s = req_vpos + V_ONE;
            end
        end else begin
            v_nxt_s = req_vpos;
        end
    end

    // Decode request-stage flags for the position about to be registered
    always_comb begin
        h_ext_s            = {1'b0, h_nxt_s};
        v_ext_s            = {1'b0, v_nxt_s};
        flags_nxt_s        = 5'b00000;
        flags_nxt_s[P_REQ] = (h_ext_s < H_ACT_END) && (v_ext_s < V_ACT_END);
        flags_nxt_s[P_HS]  = (h_ext_s >= HS_BEG) && (h_ext_s < HS_END);
        flags_nxt_s[P_VS]  = (v_ext_s >= VS_BEG) && (v_ext_s < VS_END);
        flags_nxt_s[P_LS]  = (h_nxt_s == H_ZERO) && (v_ext_s < V_ACT_END);
        flags_nxt_s[P_FS]  = (h_nxt_s == H_ZERO) && (v_nxt_s == V_ZERO);
    end

    // Counters, request flags and the latency-matching delay line
    always_ff @(posedge vid_clk) begin
        if (reset) begin
            req_hpos   <= H_LAST;
            req_vpos   <= V_LAST;
            stage_r[0] <= 5'b00000;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                stage_r[i] <= 5'b00000;
            end
        end else begin
            req_hpos   <= h_nxt_s;
            req_vpos   <= v_nxt_s;
            stage_r[0] <= flags_nxt_s;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign pix_req = stage_r[0][P_REQ];
    assign tail_s  = stage_r[READ_LATENCY];

    // Output stage: capture pixel_in alongside the matching delayed flags
    always_ff @(posedge vid_clk) begin
        if (reset) begin
            Hsync       <= ~HS_ON;
            Vsync       <= ~VS_ON;
            Active_pix  <= 1'b0;
            pixel_out   <= {BITS_PER_PIXEL{1'b0}};
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            Hsync       <= tail_s[P_HS] ? HS_ON : ~HS_ON;
            Vsync       <= tail_s[P_VS] ? VS_ON : ~VS_ON;
            Active_pix  <= tail_s[P_REQ];
            pixel_out   <= tail_s[P_REQ] ? pixel_in : {BITS_PER_PIXEL{1'b0}};
            line_start  <= tail_s[P_LS];
            frame_start <= tail_s[P_FS];
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: three instances (default 800x525 RL=2,
// small 25x10 RL=3 with positive syncs, tiny 8x5 RL=0) run side by side
// against a raster model computed from the cycle index since reset release.
module tb_vid_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    localparam int HR [3] = '{640, 16, 4};
    localparam int HF [3] = '{16, 2, 1};
    localparam int HS [3] = '{96, 4, 2};
    localparam int HB [3] = '{48, 3, 1};
    localparam int VR [3] = '{480, 6, 2};
    localparam int VF [3] = '{10, 1, 1};
    localparam int VS [3] = '{2, 2, 1};
    localparam int VB [3] = '{33, 1, 1};
    localparam int HP [3] = '{0, 1, 0};
    localparam int VP [3] = '{0, 1, 0};
    localparam int RL [3] = '{2, 3, 0};
    localparam int HBITS [3] = '{10, 5, 3};

    int total = 0;
    int bad = 0;
    int k = -1;   // request index since reset release; -1 while in reset

    logic        pr0, hs0, vs0, act0, ls0, fs0;
    logic [9:0]  hp0, vp0;
    logic [23:0] pin0 = 24'd0, pout0;
    logic        pr1, hs1, vs1, act1, ls1, fs1;
    logic [4:0]  hp1;
    logic [3:0]  vp1;
    logic [23:0] pin1 = 24'd0, pout1;
    logic        pr2, hs2, vs2, act2, ls2, fs2;
    logic [2:0]  hp2, vp2;
    logic [7:0]  pin2 = 8'd0, pout2;

    vid_timing_gen #(.H_RES_PIX(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_RES_PIX(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .READ_LATENCY(2), .BITS_PER_PIXEL(24)) dut0 (
        .vid_clk(clk), .reset(reset), .pix_req(pr0), .req_hpos(hp0), .req_vpos(vp0),
        .pixel_in(pin0), .Hsync(hs0), .Vsync(vs0), .Active_pix(act0),
        .pixel_out(pout0), .line_start(ls0), .frame_start(fs0));

    vid_timing_gen #(.H_RES_PIX(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_RES_PIX(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .READ_LATENCY(3), .BITS_PER_PIXEL(24)) dut1 (
        .vid_clk(clk), .reset(reset), .pix_req(pr1), .req_hpos(hp1), .req_vpos(vp1),
        .pixel_in(pin1), .Hsync(hs1), .Vsync(vs1), .Active_pix(act1),
        .pixel_out(pout1), .line_start(ls1), .frame_start(fs1));

    vid_timing_gen #(.H_RES_PIX(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_RES_PIX(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .READ_LATENCY(0), .BITS_PER_PIXEL(8)) dut2 (
        .vid_clk(clk), .reset(reset), .pix_req(pr2), .req_hpos(hp2), .req_vpos(vp2),
        .pixel_in(pin2), .Hsync(hs2), .Vsync(vs2), .Active_pix(act2),
        .pixel_out(pout2), .line_start(ls2), .frame_start(fs2));

    // Observed request stage {hpos, vpos, pix_req} and output stage
    // {Hsync, Vsync, Active_pix, line_start, frame_start, pixel_out}
    logic [32:0] obs_req [3];
    logic [36:0] obs_out [3];
    assign obs_req[0] = {16'(hp0), 16'(vp0), pr0};
    assign obs_req[1] = {16'(hp1), 16'(vp1), pr1};
    assign obs_req[2] = {16'(hp2), 16'(vp2), pr2};
    assign obs_out[0] = {hs0, vs0, act0, ls0, fs0, 32'(pout0)};
    assign obs_out[1] = {hs1, vs1, act1, ls1, fs1, 32'(pout1)};
    assign obs_out[2] = {hs2, vs2, act2, ls2, fs2, 32'(pout2)};

    function automatic int ht(int d);
        return HR[d] + HF[d] + HS[d] + HB[d];
    endfunction

    function automatic int vt(int d);
        return VR[d] + VF[d] + VS[d] + VB[d];
    endfunction

    // Raster position of request number n
    function automatic bit is_active(int d, int n);
        int h = n % ht(d);
        int v = (n / ht(d)) % vt(d);
        return (h < HR[d]) && (v < VR[d]);
    endfunction

    function automatic logic [31:0] coord(int d, int n);
        int h = n % ht(d);
        int v = (n / ht(d)) % vt(d);
        return (32'(v) << HBITS[d]) | 32'(h);
    endfunction

    function automatic logic [32:0] exp_req(int d, int n);
        int h, v;
        logic p;
        if (n < 0) begin
            h = ht(d) - 1;
            v = vt(d) - 1;
            p = 1'b0;
        end else begin
            h = n % ht(d);
            v = (n / ht(d)) % vt(d);
            p = is_active(d, n);
        end
        return {16'(h), 16'(v), p};
    endfunction

    // Output stage shows request n-RL-1, all blank before that
    function automatic logic [36:0] exp_out(int d, int n);
        int ko = n - RL[d] - 1;
        int h, v;
        logic hsa = 1'b0, vsa = 1'b0, a = 1'b0, l = 1'b0, f = 1'b0;
        logic [31:0] px = 32'd0;
        if (ko >= 0) begin
            h   = ko % ht(d);
            v   = (ko / ht(d)) % vt(d);
            a   = is_active(d, ko);
            hsa = (h >= HR[d] + HF[d]) && (h < HR[d] + HF[d] + HS[d]);
            vsa = (v >= VR[d] + VF[d]) && (v < VR[d] + VF[d] + VS[d]);
            l   = (h == 0) && (v < VR[d]);
            f   = (h == 0) && (v == 0);
            if (a) px = coord(d, ko);
        end
        return {(hsa ? 1'(HP[d]) : ~1'(HP[d])), (vsa ? 1'(VP[d]) : ~1'(VP[d])), a, l, f, px};
    endfunction

    // Buffer model: returns the requested coordinate RL cycles after an
    // active request, random junk otherwise
    function automatic logic [31:0] src_pix(int d, int n);
        int kp = n - RL[d];
        if (kp >= 0 && is_active(d, kp)) return coord(d, kp);
        return $urandom;
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset) k = -1;
        else k = k + 1;
        #1;
        pin0 = 24'(src_pix(0, k));
        pin1 = 24'(src_pix(1, k));
        pin2 = 8'(src_pix(2, k));
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs_req[d] !== exp_req(d, -1)) begin
                bad++;
                $display("FAIL reset_req d%0d got=%h exp=%h", d, obs_req[d], exp_req(d, -1));
            end
            total++;
            if (obs_out[d] !== exp_out(d, -1)) begin
                bad++;
                $display("FAIL reset_out d%0d got=%h exp=%h", d, obs_out[d], exp_out(d, -1));
            end
        end
        total++;
        if ({hs0, vs0, act0, hp0, vp0} !== {1'b1, 1'b1, 1'b0, 10'd799, 10'd524}) begin
            bad++;
            $display("FAIL reset_d0_const got=%b%b%b %0d %0d", hs0, vs0, act0, hp0, vp0);
        end
        total++;
        if ({hs1, vs1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_d1_pol got=%b%b exp=00", hs1, vs1);
        end
        reset = 1'b0;
    endtask

    task automatic test_default_timing();
        int first_act = -1, first_fs = -1, first_hl = -1, hl_len = 0;
        for (int c = 0; c < 3 * 800 + 10; c++) begin
            step();
            if (k == 0) begin
                total++;
                if (!(pr0 === 1'b1 && hp0 === 10'd0 && vp0 === 10'd0)) begin
                    bad++;
                    $display("FAIL startup_req got pr=%b h=%0d v=%0d exp pr=1 h=0 v=0", pr0, hp0, vp0);
                end
            end
            if (act0 === 1'b1 && first_act < 0) first_act = k;
            if (fs0 === 1'b1 && first_fs < 0) first_fs = k;
            if (k < 800 && hs0 === 1'b0) begin
                if (first_hl < 0) first_hl = k;
                hl_len++;
            end
            total++;
            if (obs_req[0] !== exp_req(0, k)) begin
                bad++;
                $display("FAIL dflt_req k=%0d got=%h exp=%h", k, obs_req[0], exp_req(0, k));
            end
            total++;
            if (obs_out[0] !== exp_out(0, k)) begin
                bad++;
                $display("FAIL dflt_out k=%0d got=%h exp=%h", k, obs_out[0], exp_out(0, k));
            end
        end
        total++;
        if (first_act != 3 || first_fs != 3) begin
            bad++;
            $display("FAIL first_active got act=%0d fs=%0d exp=3", first_act, first_fs);
        end
        total++;
        if (first_hl != 659 || hl_len != 96) begin
            bad++;
            $display("FAIL hsync_first got start=%0d len=%0d exp start=659 len=96", first_hl, hl_len);
        end
    endtask

    task automatic test_frames_pol();
        int run = -1, vrun = -1, hrun = -1, last_fs = -1, nruns = 0;
        logic pa = 1'b0, pv = 1'b0, ph = 1'b0;
        for (int c = 0; c < 3 * 250; c++) begin
            step();
            total++;
            if (obs_req[1] !== exp_req(1, k)) begin
                bad++;
                $display("FAIL frm_req k=%0d got=%h exp=%h", k, obs_req[1], exp_req(1, k));
            end
            total++;
            if (obs_out[1] !== exp_out(1, k)) begin
                bad++;
                $display("FAIL frm_out k=%0d got=%h exp=%h", k, obs_out[1], exp_out(1, k));
            end
            if (fs1 === 1'b1) begin
                if (last_fs >= 0) begin
                    total++;
                    if (k - last_fs != 250 || nruns != 6) begin
                        bad++;
                        $display("FAIL frame_period got=%0d runs=%0d exp=250 runs=6", k - last_fs, nruns);
                    end
                end
                last_fs = k;
                nruns = 0;
            end
            if (act1 === 1'b1 && !pa) begin run = 1; nruns++; end
            else if (act1 === 1'b1 && run >= 0) run++;
            else if (act1 !== 1'b1 && pa && run >= 0) begin
                total++;
                if (run != 16) begin
                    bad++;
                    $display("FAIL active_run got=%0d exp=16", run);
                end
            end
            if (vs1 === 1'b1 && !pv) vrun = 1;
            else if (vs1 === 1'b1 && vrun >= 0) vrun++;
            else if (vs1 !== 1'b1 && pv && vrun >= 0) begin
                total++;
                if (vrun != 50) begin
                    bad++;
                    $display("FAIL vsync_run got=%0d exp=50", vrun);
                end
            end
            if (hs1 === 1'b1 && !ph) hrun = 1;
            else if (hs1 === 1'b1 && hrun >= 0) hrun++;
            else if (hs1 !== 1'b1 && ph && hrun >= 0) begin
                total++;
                if (hrun != 4) begin
                    bad++;
                    $display("FAIL hsync_run got=%0d exp=4", hrun);
                end
            end
            pa = (act1 === 1'b1);
            pv = (vs1 === 1'b1);
            ph = (hs1 === 1'b1);
        end
    endtask

    task automatic test_small_wrap();
        logic [7:0] prev_pin;
        for (int c = 0; c < 3 * 40; c++) begin
            prev_pin = pin2;
            step();
            total++;
            if (obs_req[2] !== exp_req(2, k)) begin
                bad++;
                $display("FAIL tiny_req k=%0d got=%h exp=%h", k, obs_req[2], exp_req(2, k));
            end
            total++;
            if (obs_out[2] !== exp_out(2, k)) begin
                bad++;
                $display("FAIL tiny_out k=%0d got=%h exp=%h", k, obs_out[2], exp_out(2, k));
            end
            if (k > 0 && (k % 40) == 0) begin
                total++;
                if ({hp2, vp2, pr2} !== 7'b000_000_1) begin
                    bad++;
                    $display("FAIL tiny_wrap k=%0d got h=%0d v=%0d pr=%b exp 0 0 1", k, hp2, vp2, pr2);
                end
            end
            if (k >= 1 && is_active(2, k - 1)) begin
                total++;
                if (pout2 !== prev_pin) begin
                    bad++;
                    $display("FAIL tiny_follow k=%0d got=%h exp=%h", k, pout2, prev_pin);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        int first_act = -1;
        while ((k % 800) != 300 && guard < 900) begin
            step();
            guard++;
        end
        total++;
        if ((k % 800) != 300) begin
            bad++;
            $display("FAIL midrst_seek got=%0d exp=300", k % 800);
        end
        reset = 1'b1;
        step();
        total++;
        if ({hs0, vs0, act0, ls0, fs0, pout0, hp0, vp0, pr0} !==
            {5'b11000, 24'd0, 10'd799, 10'd524, 1'b0}) begin
            bad++;
            $display("FAIL midrst_vals got=%b%b%b%b%b %h %0d %0d %b", hs0, vs0, act0, ls0, fs0,
                     pout0, hp0, vp0, pr0);
        end
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (act0 === 1'b1 && first_act < 0) first_act = k;
            total++;
            if (obs_req[0] !== exp_req(0, k) || obs_out[0] !== exp_out(0, k)) begin
                bad++;
                $display("FAIL midrst_d0 k=%0d got=%h/%h exp=%h/%h", k, obs_req[0], obs_out[0],
                         exp_req(0, k), exp_out(0, k));
            end
            total++;
            if (obs_req[2] !== exp_req(2, k) || obs_out[2] !== exp_out(2, k)) begin
                bad++;
                $display("FAIL midrst_d2 k=%0d got=%h/%h exp=%h/%h", k, obs_req[2], obs_out[2],
                         exp_req(2, k), exp_out(2, k));
            end
        end
        total++;
        if (first_act != 3) begin
            bad++;
            $display("FAIL midrst_restart got=%0d exp=3", first_act);
        end
    endtask

    task automatic test_random_reset();
        int run_len, rst_len;
        for (int it = 0; it < 4; it++) begin
            run_len = $urandom_range(400, 50);
            rst_len = $urandom_range(4, 1);
            for (int c = 0; c < run_len; c++) begin
                step();
                for (int d = 0; d < 3; d++) begin
                    total++;
                    if (obs_req[d] !== exp_req(d, k) || obs_out[d] !== exp_out(d, k)) begin
                        bad++;
                        $display("FAIL rnd_run d%0d k=%0d got=%h/%h exp=%h/%h", d, k, obs_req[d],
                                 obs_out[d], exp_req(d, k), exp_out(d, k));
                    end
                end
            end
            reset = 1'b1;
            for (int c = 0; c < rst_len; c++) begin
                step();
                for (int d = 0; d < 3; d++) begin
                    total++;
                    if (obs_req[d] !== exp_req(d, -1) || obs_out[d] !== exp_out(d, -1)) begin
                        bad++;
                        $display("FAIL rnd_rst d%0d got=%h/%h exp=%h/%h", d, obs_req[d],
                                 obs_out[d], exp_req(d, -1), exp_out(d, -1));
                    end
                end
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_default_timing();
        test_frames_pol();
        test_small_wrap();
        test_mid_reset();
        test_random_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
